// File: rtl/tempsense_readout.sv
// Tempsense delay readout: synchronizes the delay edge, counts discharge cycles,
// latches result/timeout, and scans the result nibble-by-nibble onto the digit bus.
module tempsense_readout #(
  parameter int CNT_W      = 12,
  parameter int DISP_TICKS = 5000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic             i_tempdelay,
  output logic [CNT_W-1:0] o_result,
  output logic             o_valid,
  output logic             o_timeout,
  output logic             o_busy,
  output logic [3:0]       o_digit,
  output logic             o_blank
);

  localparam int NIB    = CNT_W / 4;
  localparam int SLOT_W = $clog2(NIB + 1);
  localparam int TICK_W = (DISP_TICKS > 1) ? $clog2(DISP_TICKS) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [SLOT_W-1:0] SLOT_BLANK = SLOT_W'(NIB);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(DISP_TICKS - 1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic               sync1_r, sync2_r;
  logic [CNT_W-1:0]   cnt_r, cnt_s, result_s;
  logic               valid_s, timeout_s;
  logic [SLOT_W-1:0]  slot_r, slot_s;
  logic [TICK_W-1:0]  tick_r, tick_s;
  logic [3:0]         digit_s;
  logic               blank_s;

  // Slot 0 is the most significant nibble; slots past the last nibble read as zero.
  function automatic logic [3:0] nibble_at(input logic [CNT_W-1:0] value,
                                           input logic [SLOT_W-1:0] slot);
    logic [CNT_W-1:0] shifted;
    if (int'(slot) >= NIB) begin
      return 4'h0;
    end else begin
      shifted = value >> (4 * (NIB - 1 - int'(slot)));
      return shifted[3:0];
    end
  endfunction

  // Two-flop synchronizer for the asynchronous delay edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= i_tempdelay;
      sync2_r <= sync1_r;
    end
  end

  // Measurement FSM next state: restart beats detection, detection beats timeout.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    result_s  = o_result;
    timeout_s = o_timeout;
    valid_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_s = ST_MEASURE;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        if (i_start) begin
          cnt_s = {CNT_W{1'b0}};
        end else if (sync2_r) begin
          result_s  = cnt_r;
          timeout_s = 1'b0;
          valid_s   = 1'b1;
          state_s   = ST_IDLE;
        end else if (cnt_r == CNT_MAX) begin
          result_s  = CNT_MAX;
          timeout_s = 1'b1;
          valid_s   = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Measurement state, counter and latched result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      o_result  <= {CNT_W{1'b0}};
      o_timeout <= 1'b0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      o_result  <= result_s;
      o_timeout <= timeout_s;
      o_valid   <= valid_s;
      o_busy    <= (state_s == ST_MEASURE);
    end
  end

  // Display sequencer next state; a fresh result restarts the scan at the MSB nibble.
  always_comb begin
    slot_s = slot_r;
    tick_s = tick_r;
    if (valid_s) begin
      slot_s = {SLOT_W{1'b0}};
      tick_s = {TICK_W{1'b0}};
    end else if (tick_r == TICK_LAST) begin
      tick_s = {TICK_W{1'b0}};
      if (slot_r == SLOT_BLANK) begin
        slot_s = {SLOT_W{1'b0}};
      end else begin
        slot_s = slot_r + {{(SLOT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      tick_s = tick_r + {{(TICK_W-1){1'b0}}, 1'b1};
    end
  end

  // Digit/blank decode for the current slot.
  always_comb begin
    digit_s = 4'h0;
    blank_s = 1'b1;
    if (slot_r == SLOT_BLANK) begin
      digit_s = 4'h0;
      blank_s = 1'b1;
    end else begin
      digit_s = nibble_at(o_result, slot_r);
      blank_s = 1'b0;
    end
  end

  // Display slot/tick counters and registered digit outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_r  <= {SLOT_W{1'b0}};
      tick_r  <= {TICK_W{1'b0}};
      o_digit <= 4'h0;
      o_blank <= 1'b1;
    end else begin
      slot_r  <= slot_s;
      tick_r  <= tick_s;
      o_digit <= digit_s;
      o_blank <= blank_s;
    end
  end

endmodule

// File: doc/tempsense_readout.md
Name: tempsense_readout

Overview:
Receiving end of the temperature-sensor delay path. Takes the asynchronous delay output of the tempsense macro and a start pulse from the sensor controller, and converts the discharge delay into a clock-cycle count. Latches the result with a timeout flag, and multiplexes the result nibble-by-nibble onto a 4-bit digit bus for the seg7 decoder. Sits between tempsense (o_tempdelay) and seg7 (i_disp) on the 10 kHz design clock.

Parameters:
CNT_W, 12, width of delay counter and latched result; must be a multiple of 4, minimum 4
DISP_TICKS, 5000, clock cycles each display slot is held (0.5 s at 10 kHz); minimum 1

Ports:
clk  input  1  design clock, rising-edge
reset_n  input  1  asynchronous active-low reset
i_start  input  1  one-cycle pulse from the controller at entry to the measure phase (precharge released)
i_tempdelay  input  1  raw tempsense delay output; asynchronous; rises when discharge completes
o_result  output  CNT_W  last latched delay count
o_valid  output  1  one-cycle pulse when o_result/o_timeout update
o_timeout  output  1  high when the last measurement saturated without a detected rise
o_busy  output  1  high while measuring
o_digit  output  4  nibble to seg7 i_disp
o_blank  output  1  high during the separator slot; blanks the display

Behaviour:
- Reset (async assert, sync-released by clk) values: state IDLE; counter 0; o_result 0; o_valid 0; o_timeout 0; o_busy 0; o_digit 0; o_blank 1; slot index 0; tick counter 0; sync flops 0.
- Synchronizer: 2-flop on i_tempdelay -> s2. Only s2 is used downstream. A rise on i_tempdelay is visible on s2 two clk edges later.
- FSM states: IDLE, MEASURE.
  - IDLE: o_busy=0. i_start=1 at an edge -> MEASURE, counter<=0.
  - MEASURE: o_busy=1. Evaluated at each edge, in priority order:
    1. i_start=1 -> restart: counter<=0, stay in MEASURE, no o_valid.
    2. s2=1 -> o_result<=counter, o_timeout<=0, o_valid pulse, go to IDLE.
    3. counter == 2^CNT_W-1 -> o_result<=all-ones, o_timeout<=1, o_valid pulse, go to IDLE.
    4. Otherwise counter<=counter+1.
  - Detection is level-based: s2 already high in the first MEASURE cycle gives o_result=0, reported as valid, not timeout.
- Latency: with i_tempdelay rising between edges, o_result = (edges from start-accept to rise) + 2, fixed by the synchronizer and not compensated.
- o_valid is registered and high for exactly one cycle, on the cycle o_result changes.
- i_start in IDLE while s2 is high is legal and yields result 0 on the next edge.
- Display sequencer (free-running, independent of FSM):
  - NIB = CNT_W/4 nibble slots plus 1 blank slot; each slot lasts DISP_TICKS cycles.
  - Slot 0 shows o_result[CNT_W-1:CNT_W-4] (MSB first) through slot NIB-1 showing o_result[3:0].
  - Slot NIB: o_blank=1, o_digit=0. Then wraps to slot 0.
  - o_blank=0 during nibble slots.
  - When o_valid fires, slot and tick counters reset to slot 0, tick 0 on the same edge. This restart overrides the wrap.
  - o_digit and o_blank are registered and track o_result combinationally within the slot, so a new value appears the cycle after o_valid.
- Reset mid-measurement: aborts immediately to the reset values; no o_valid.
- Counter and result arithmetic are unsigned, CNT_W bits; the counter never wraps (saturates via timeout).

Test Plan:
1. Reset with CNT_W=12, DISP_TICKS=4 -> all outputs at reset values; o_blank=1; o_digit cycles slot 0..3 only after reset release.
2. i_start pulse, i_tempdelay rises 10 edges later -> o_valid single pulse, o_result=12 (0x00C), o_timeout=0, o_busy falls the same cycle o_valid rises.
3. Display after case 2 -> o_digit 0,0,C for 4 cycles each, then o_blank=1 for 4 cycles, then repeats.
4. i_start with i_tempdelay held low, CNT_W=4 -> after 16 edges o_result=0xF, o_timeout=1, o_valid pulse; next good measurement of 5 -> o_timeout=0, o_result=7.
5. i_start re-pulsed 5 cycles into MEASURE, then rise 3 edges after the second start -> o_result=5, only one o_valid.
6. reset_n low mid-MEASURE (asynchronously, between edges) -> outputs at reset values immediately; no o_valid; i_tempdelay already high at the next start -> o_result=0.
